// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multicycle load/store sequencer between the control unit, main memory,
// the MDR and the load-size selector. One access is taken at a time.
// Loads read memory, pulse the MDR load and present the load-size select.
// Sub-word stores read the addressed word, merge the low bits and write it back.
//
// Parameters:
//   MEM_LAT    memory read latency in cycles (1..4)
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req        start request, sampled only in IDLE
//   op         000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB (011/111 illegal)
//   addr       access address, latched on acceptance
//   store_data store operand, latched on acceptance
//   mem_addr   registered memory address
//   mem_wr     one-cycle memory write strobe
//   mem_wdata  registered memory write data
//   mem_rdata  memory read data
//   mdr_load   one-cycle MDR load enable
//   ls_sel     load-size select: 00 word, 10 half, 01 byte
//   busy       access in progress (cycle after acceptance through FIN)
//   done       one-cycle completion pulse
//   err        one-cycle illegal-op pulse
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mdr_load,
    output logic [1:0]  ls_sel,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SB = 3'b110;

    // Counter value on the final RD cycle.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    // Opcode legality check.
    function automatic logic op_legal(input logic [2:0] o);
        logic ok;
        case (o)
            OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Load-size select code for a load opcode.
    function automatic logic [1:0] ls_code(input logic [2:0] o);
        logic [1:0] c;
        case (o)
            OP_LH:   c = 2'b10;
            OP_LB:   c = 2'b01;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // Sub-word store merge: new low bits from the buffer, upper bits from memory.
    function automatic logic [31:0] merge_word(input logic [2:0]  o,
                                               input logic [31:0] rd,
                                               input logic [31:0] b);
        logic [31:0] w;
        case (o)
            OP_SH:   w = {rd[31:16], b[15:0]};
            OP_SB:   w = {rd[31:8],  b[7:0]};
            default: w = b;
        endcase
        return w;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  ls_sel_q, ls_sel_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mdr_load_q, mdr_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Next-state and datapath decode; strobes are derived from the next state
    // so that the registered outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        buf_d       = buf_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ls_sel_d    = ls_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (op_legal(op)) begin
                        op_d       = op;
                        mem_addr_d = addr;
                        buf_d      = store_data;
                        cnt_d      = 2'd0;
                        if (op == OP_SW) begin
                            // Full-word store needs no read; data goes out directly.
                            mem_wdata_d = store_data;
                            state_d     = ST_WR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_q == LAT_LAST) begin
                    if (op_q[2]) begin
                        mem_wdata_d = merge_word(op_q, mem_rdata, buf_q);
                        state_d     = ST_WR;
                    end else begin
                        ls_sel_d = ls_code(op_q);
                        state_d  = ST_CAP;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_CAP:  state_d = ST_FIN;
            ST_WR:   state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        mem_wr_d   = (state_d == ST_WR);
        mdr_load_d = (state_d == ST_CAP);
        done_d     = (state_d == ST_FIN);
        err_d      = (state_d == ST_ERR);
        busy_d     = (state_d == ST_RD) || (state_d == ST_CAP) ||
                     (state_d == ST_WR) || (state_d == ST_FIN);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            op_q        <= 3'd0;
            buf_q       <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            ls_sel_q    <= 2'b00;
            mem_wr_q    <= 1'b0;
            mdr_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            buf_q       <= buf_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ls_sel_q    <= ls_sel_d;
            mem_wr_q    <= mem_wr_d;
            mdr_load_q  <= mdr_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign mdr_load  = mdr_load_q;
    assign ls_sel    = ls_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl. Two instances share the request
// inputs: u_d1 with MEM_LAT=1 and u_d2 with MEM_LAT=2. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;

    logic [31:0] a1, w1, a2, w2;
    logic        wr1, ml1, by1, dn1, er1;
    logic        wr2, ml2, by2, dn2, er2;
    logic [1:0]  ls1, ls2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(1)) u_d1 (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
        .store_data(store_data), .mem_addr(a1), .mem_wr(wr1), .mem_wdata(w1),
        .mem_rdata(mem_rdata), .mdr_load(ml1), .ls_sel(ls1), .busy(by1),
        .done(dn1), .err(er1)
    );

    mem_access_ctrl #(.MEM_LAT(2)) u_d2 (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
        .store_data(store_data), .mem_addr(a2), .mem_wr(wr2), .mem_wdata(w2),
        .mem_rdata(mem_rdata), .mdr_load(ml2), .ls_sel(ls2), .busy(by2),
        .done(dn2), .err(er2)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next sample point (cycle k after the request edge).
    task automatic cyc();
        @(negedge clk);
    endtask

    // Present a request; it is accepted on the next rising edge (edge 0).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        req        = 1'b1;
        op         = o;
        addr       = a;
        store_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset = 1'b1; req = 1'b0; op = 3'd0; addr = 32'd0;
        store_data = 32'd0; mem_rdata = 32'd0;
        cyc();
        // Reset state
        check_val("rst_addr",  a1, 32'd0);
        check_val("rst_wdata", w1, 32'd0);
        check_val("rst_strb",  {27'd0, wr1, ml1, by1, dn1, er1}, 32'd0);
        check_val("rst_ls",    {30'd0, ls1}, 32'd0);
        reset = 1'b0;

        // SW addr 0x40 data 0xDEADBEEF
        issue(3'b100, 32'h40, 32'hDEADBEEF);
        cyc(); req = 1'b0;                                   // cycle 1
        check_val("sw_wr_c1",   {31'd0, wr1}, 32'd1);
        check_val("sw_addr_c1", a1, 32'h40);
        check_val("sw_wdata_c1", w1, 32'hDEADBEEF);
        check_val("sw_busy_c1", {31'd0, by1}, 32'd1);
        cyc();                                               // cycle 2
        check_val("sw_done_c2", {31'd0, dn1}, 32'd1);
        check_val("sw_wr_c2",   {31'd0, wr1}, 32'd0);
        cyc();                                               // cycle 3
        check_val("sw_idle_c3", {30'd0, by1, dn1}, 32'd0);
        check_val("sw_addr_hold", a1, 32'h40);

        // LH, rdata 0x12345678 (u_d2: MEM_LAT=2, u_d1: MEM_LAT=1)
        mem_rdata = 32'h12345678;
        issue(3'b001, 32'h100, 32'd0);
        cyc(); req = 1'b0;                                   // cycle 1
        check_val("lh2_ml_c1", {31'd0, ml2}, 32'd0);
        cyc();                                               // cycle 2
        check_val("lh2_ml_c2", {31'd0, ml2}, 32'd0);
        check_val("lh1_ml_c2", {31'd0, ml1}, 32'd1);
        check_val("lh1_ls_c2", {30'd0, ls1}, 32'h2);
        cyc();                                               // cycle 3
        check_val("lh2_ml_c3", {31'd0, ml2}, 32'd1);
        check_val("lh2_ls_c3", {30'd0, ls2}, 32'h2);
        check_val("lh1_done_c3", {31'd0, dn1}, 32'd1);
        cyc();                                               // cycle 4
        check_val("lh2_done_c4", {31'd0, dn2}, 32'd1);
        check_val("lh2_ml_c4",   {31'd0, ml2}, 32'd0);
        cyc();                                               // cycle 5
        check_val("lh2_ls_hold", {30'd0, ls2}, 32'h2);
        check_val("lh2_idle_c5", {30'd0, by2, dn2}, 32'd0);

        // SB addr 0x80, data 0xFFFFFFAB, rdata 0x11223344 (u_d1)
        mem_rdata = 32'h11223344;
        issue(3'b110, 32'h80, 32'hFFFFFFAB);
        cyc(); req = 1'b0;                                   // cycle 1
        check_val("sb_wr_c1", {31'd0, wr1}, 32'd0);
        cyc();                                               // cycle 2
        check_val("sb_wr_c2",    {31'd0, wr1}, 32'd1);
        check_val("sb_wdata_c2", w1, 32'h112233AB);
        check_val("sb_addr_c2",  a1, 32'h80);
        cyc();                                               // cycle 3
        check_val("sb_done_c3", {31'd0, dn1}, 32'd1);
        check_val("sb_ls_keep", {30'd0, ls1}, 32'h2);
        cyc(); cyc();                                        // u_d2 finishes

        // SH, data 0x0000CAFE, rdata 0xAAAABBBB, req toggled while busy
        mem_rdata = 32'hAAAABBBB;
        issue(3'b101, 32'h84, 32'h0000CAFE);
        cyc();                                               // cycle 1
        issue(3'b100, 32'h999, 32'h55555555);                // ignored
        cyc();                                               // cycle 2
        req = 1'b0;
        check_val("sh_wr_c2",    {31'd0, wr1}, 32'd1);
        check_val("sh_wdata_c2", w1, 32'hAAAACAFE);
        check_val("sh_addr_c2",  a1, 32'h84);
        cyc();                                               // cycle 3
        check_val("sh_done_c3", {31'd0, dn1}, 32'd1);
        cyc(); cyc();                                        // cycle 5
        check_val("sh_no_new1", {30'd0, by1, wr1}, 32'd0);
        cyc();                                               // cycle 6
        check_val("sh_no_new2", {30'd0, by2, wr2}, 32'd0);
        check_val("sh2_wdata",  w2, 32'hAAAACAFE);

        // Illegal op 011, then LB accepted at the end of cycle 2
        issue(3'b011, 32'h300, 32'd0);
        cyc();                                               // cycle 1
        check_val("ill_err_c1",  {31'd0, er1}, 32'd1);
        check_val("ill_quiet_c1", {29'd0, wr1, ml1, dn1}, 32'd0);
        check_val("ill_addr_c1", a1, 32'h84);
        issue(3'b010, 32'h200, 32'd0);
        cyc();                                               // cycle 2
        check_val("ill_err_c2", {31'd0, er1}, 32'd0);
        check_val("ill_quiet_c2", {29'd0, wr1, ml1, dn1}, 32'd0);
        cyc(); req = 1'b0;                                   // cycle 3
        check_val("lb_addr_c3", a1, 32'h200);
        check_val("lb_busy_c3", {31'd0, by1}, 32'd1);
        cyc();                                               // cycle 4
        check_val("lb_ml_c4", {31'd0, ml1}, 32'd1);
        check_val("lb_ls_c4", {30'd0, ls1}, 32'h1);
        cyc();                                               // cycle 5
        check_val("lb_done_c5", {31'd0, dn1}, 32'd1);
        cyc(); cyc();

        // Reset mid-RD of an LW on u_d2
        issue(3'b000, 32'h300, 32'd0);
        cyc(); req = 1'b0;                                   // cycle 1 (RD)
        check_val("lw_busy_pre", {31'd0, by2}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("arst_addr", a2, 32'd0);
        check_val("arst_strb", {27'd0, wr2, ml2, by2, dn2, er2}, 32'd0);
        check_val("arst_ls",   {30'd0, ls2}, 32'd0);
        cyc();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            seen = seen | dn2 | ml2 | by2;
        end
        check_val("arst_no_done", {31'd0, seen}, 32'd0);

        // SW after reset release
        issue(3'b100, 32'h44, 32'h01020304);
        cyc(); req = 1'b0;                                   // cycle 1
        check_val("sw2_wr_c1",    {31'd0, wr2}, 32'd1);
        check_val("sw2_wdata_c1", w2, 32'h01020304);
        check_val("sw2_addr_c1",  a2, 32'h44);
        cyc();                                               // cycle 2
        check_val("sw2_done_c2", {31'd0, dn2}, 32'd1);
        check_val("sw2_err", {30'd0, er1, er2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle load/store sequencer between the control unit, main memory, MDR and the load-size selector. It accepts one access request (LW/LH/LB/SW/SH/SB) and drives the memory address, write strobe and write data. For loads it waits the memory read latency, pulses the MDR load and presents the select code for the load-size selector. Sub-word stores are performed as read-modify-write on the low bits of the addressed word, matching the load-size convention. It reports completion with a one-cycle `done` pulse.

## Interface
- `MEM_LAT`, 1: memory read latency in cycles, legal range 1..4.

- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and the reset values of all outputs.
- `req` in 1: start request; sampled only in IDLE.
- `op` in 3: operation code.
  - 000 LW, 001 LH, 010 LB.
  - 100 SW, 101 SH, 110 SB.
  - 011 and 111 are illegal.
- `addr` in 32: access address, latched on acceptance.
- `store_data` in 32: store operand (register B value), latched on acceptance.
- `mem_addr` out 32: registered memory address; reset 0.
- `mem_wr` out 1: memory write strobe; reset 0.
- `mem_wdata` out 32: registered write data; reset 0.
- `mem_rdata` in 32: memory read data, valid `MEM_LAT` cycles after `mem_addr` is presented.
- `mdr_load` out 1: one-cycle MDR load enable; reset 0.
- `ls_sel` out 2: load-size select code; reset 00.
  - 00 word, 10 half, 01 byte.
- `busy` out 1: high from the cycle after acceptance through the FIN cycle; reset 0.
- `done` out 1: one-cycle completion pulse; reset 0.
- `err` out 1: one-cycle illegal-op pulse; reset 0.

## Operation
- States: IDLE, RD, CAP, WR, FIN, ERR.
- IDLE, `req`=1, legal op: latch op, `addr` into `mem_addr`, `store_data` into an internal buffer; clear the latency counter. Next state:
  - SW → WR.
  - All other legal ops → RD.
- IDLE, `req`=1, illegal op: → ERR. ERR asserts `err` for one cycle, makes no memory access, never asserts `done`, then → IDLE.
- RD: `mem_wr`=0; the counter counts `MEM_LAT` cycles. On the last RD cycle:
  - Loads → CAP.
  - SH/SB: register the merged word and → WR.
    - SH merge: {`mem_rdata[31:16]`, buf[15:0]}.
    - SB merge: {`mem_rdata[31:8]`, buf[7:0]}.
- CAP: `mdr_load`=1 for exactly this cycle; `ls_sel` is updated from op at CAP entry → FIN.
- WR: `mem_wr`=1 for exactly one cycle with `mem_wdata` stable (SW: buffer as-is; SH/SB: merged word) → FIN.
- FIN: `done`=1, `busy`=1 → IDLE.
- `ls_sel` holds its value until the next load reaches CAP. Stores never change it.
- `mem_addr` and `mem_wdata` hold their values after completion.
- `req` outside IDLE is ignored. There is no queuing; a request held high in IDLE after FIN starts a new access.
- No alignment checks: the address is passed through unmodified.

## Timing
Request accepted at edge 0; cycle k means the cycle after edge k.
- SW: WR in cycle 1, `done` in cycle 2.
- LW/LH/LB: RD in cycles 1..`MEM_LAT`, CAP (`mdr_load`) in cycle `MEM_LAT`+1, `done` in cycle `MEM_LAT`+2.
- SH/SB: RD in cycles 1..`MEM_LAT`, WR in cycle `MEM_LAT`+1, `done` in cycle `MEM_LAT`+2.
- Illegal op: `err` in cycle 1; IDLE again in cycle 2.
- `mem_wr`, `mdr_load`, `done` and `err` are mutually exclusive and never exceed one cycle per access.
- Back-to-back: the next request can be accepted at the edge ending FIN+1 (IDLE), i.e. one idle cycle between accesses.
- Reset asserted mid-access (including during WR): outputs go to reset values immediately without waiting for a clock edge, and no `done` or `mdr_load` is produced.
- Reset released: the first acceptance can occur on the first rising edge with `reset`=0.

## Test plan
- Reset: assert `reset` mid-RD of an LW.
  - All outputs go to their reset values immediately, the FSM returns to IDLE, and no `done` follows.
  - After release, an SW is accepted normally.
- SW: `addr`=0x40, `store_data`=0xDEADBEEF.
  - `mem_wr`=1 in cycle 1 with `mem_addr`=0x40 and `mem_wdata`=0xDEADBEEF.
  - `done` in cycle 2.
- LH with `MEM_LAT`=2, `mem_rdata`=0x12345678.
  - `mdr_load` in cycle 3 with `ls_sel`=10.
  - `done` in cycle 4; `ls_sel` stays 10 afterwards.
- SB, `MEM_LAT`=1: `addr`=0x80, `store_data`=0xFFFFFFAB, `mem_rdata`=0x11223344.
  - `mem_wr` in cycle 2 with `mem_wdata`=0x112233AB.
  - `done` in cycle 3.
- SH, `MEM_LAT`=1: `store_data`=0x0000CAFE, `mem_rdata`=0xAAAABBBB.
  - `mem_wdata`=0xAAAACAFE.
  - `req` toggled during busy is ignored.
- Illegal `op`=011: `err` in cycle 1.
  - `mem_wr`, `mdr_load` and `done` stay 0.
  - An LB accepted in cycle 2 completes with `ls_sel`=01.
